fp_norm_arbiter: RTL and testbench
==================================

// Module: fp_norm_arbiter
// PURPOSE
//  Shares one combinational fp32 normalizer between NUM_REQ requesters (adder, multiplier, divider result paths).
//  - Round-robin arbitration over valid/ready request channels.
//  - Normalizes the granted word into a one-entry output register.
//  - Returns the result tagged with the requester index on a single valid/ready output channel.
// PARAMETERS
//  NUM_REQ   4   number of requester channels, 2..8
//  ID_W      2   width of out_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  req_valid  in   NUM_REQ     per-requester valid
//  req_data   in   NUM_REQ*32  fp32 words; channel i at [32*i+31:32*i]
//  req_ready  out  NUM_REQ     one-hot grant/accept; at most one bit set per cycle
//  out_valid  out  1           output register holds a result
//  out_data   out  32          normalized fp32 {sign, exp[7:0], frac[22:0]}
//  out_id     out  ID_W        index of the requester that produced out_data
//  out_ready  in   1           downstream accepts the result
//  grant_cnt  out  16          grants issued; present only with FP_NORM_PERF_EN
// BEHAVIOUR
//  Reset
//  - out_valid=0, out_data=0, out_id=0, rr pointer=0, req_ready=0, grant_cnt=0.
//  - Reset mid-transfer discards the held result without a handshake.
//  Accept condition
//  - slot_free = !out_valid | out_ready.
//  - req_ready is combinational: one-hot on the first valid channel at or after the rr pointer, cyclic order.
//  - req_ready is gated by slot_free and is all-zero in any cycle where rst=1.
//  Transfer and latency
//  - A transfer happens when req_valid[i] & req_ready[i].
//  - Next edge: out_data = normalized word, out_id = i, out_valid = 1.
//  - Latency is 1 cycle from accept to out_valid.
//  - Sustained throughput is 1 result/cycle when out_ready is held high.
//  Output hold and drain
//  - out_valid & !out_ready: out_data and out_id hold, and no requester is granted.
//  - Drain with no new grant: out_valid -> 0 on the next edge.
//  - Drain with a same-cycle grant: the register reloads, out_valid stays 1.
//  Round-robin pointer
//  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
//  - No grant: pointer unchanged.
//  - Wrap: a grant to NUM_REQ-1 sets the pointer to 0.
//  Normalization arithmetic (fp_norm_core, combinational)
//  - Input is {s, e[7:0], f[22:0]}.
//  - f==0: output equals input unchanged.
//  - Otherwise: lz = leading zeros of f (0..22), shift = lz+1 (1..23). The leading one becomes the hidden bit.
//  - f_out = (f << shift)[22:0], zero-filled on the right.
//  - e_out = e - shift, computed at 9 bits.
//  - If e <= shift (9-bit result <= 0): underflow, output {s, 8'h00, 23'h0}.
//  - Sign always passes through.
//  - No rounding is performed. The shift is bounded: no shift above 23 is ever applied.
//  Simultaneous events
//  - Requester drops valid in the same cycle it is pointed at: no grant to it; the next valid channel wins.
//  - All req_valid=0: no grant, pointer held.
// CONFIGURATION
//  FP_NORM_PERF_EN defined
//  - grant_cnt port exists.
//  - Increments by 1 per transfer and saturates at 16'hFFFF.
//  - Reset to 0.
//  FP_NORM_PERF_EN undefined
//  - Port and counter are absent.
//  - All other behaviour is identical.
// STRUCTURE
//  Package fp_norm_pkg
//  - Constants: FP_W=32, EXP_W=8, FRAC_W=23, EXP_LSB=23.
//  - Typedef fp32_t packed {sign, exp, frac}.
//  - Function clz23 returning a 5-bit count.
//  Sub-module fp_norm_core
//  - Purely combinational: fp32 in, fp32 out, plus a 5-bit shift output for checking.
//  Top-level contents
//  - Arbiter (rotate, priority-pick, rotate back).
//  - Output register, rr pointer, optional counter.
// TESTING
//  1. Single requester: ch0 sends 32'h4080_0000 (f=0) -> 1 cycle later out_data=32'h4080_0000, out_id=0.
//  2. Shift and exponent: ch1 sends 32'h4100_1000 (e=0x82, f=0x001000, lz=10, shift=11)
//     -> out_data=32'h3B80_0000 (e=0x77, f=0), out_id=1.
//  3. Underflow: 32'h8180_0001 (e=3, shift=23) -> out_data=32'h8000_0000.
//  4. Round-robin with all 4 valid and out_ready=1: grants 0,1,2,3,0 on consecutive cycles;
//     out_id follows 1 cycle behind.
//  5. Backpressure:
//     - out_ready=0 for 5 cycles: out_data stable, req_ready=0.
//     - Release: the same-cycle reload keeps out_valid=1.
//  6. Reset mid-stream with rst=1 and out_valid=1: next cycle out_valid=0, pointer=0;
//     with FP_NORM_PERF_EN, grant_cnt=0.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared fp32 field layout and the leading-zero helper used by the normalizer.
package fp_norm_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned EXP_LSB = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Leading zeros of a 23-bit fraction; an all-zero input yields 23.
  function automatic logic [4:0] clz23(input logic [FRAC_W-1:0] f);
    logic [4:0] n;
    logic       done;
    n    = '0;
    done = 1'b0;
    for (int unsigned k = 0; k < FRAC_W; k++) begin
      if (!done) begin
        if (f[FRAC_W-1-k]) done = 1'b1;
        else               n    = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_norm_core.sv
// Combinational fp32 normalizer: promotes the leading fraction one to the hidden bit.
module fp_norm_core
  import fp_norm_pkg::*;
(
  input  logic [FP_W-1:0] din,
  output logic [FP_W-1:0] dout,
  output logic [4:0]      shift
);

  fp32_t a;
  fp32_t y;

  always_comb begin
    a     = fp32_t'(din);
    y     = a;
    shift = '0;
    if (a.frac != '0) begin
      shift  = clz23(a.frac) + 5'd1;
      y.frac = a.frac << shift;
      // Exponent would reach zero or below: flush to signed zero.
      if ({1'b0, a.exp} <= {4'b0000, shift}) begin
        y.exp  = '0;
        y.frac = '0;
      end else begin
        y.exp = a.exp - {3'b000, shift};
      end
    end
    dout = y;
  end

endmodule

// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter sharing one fp32 normalizer among NUM_REQ requesters.
// Optional grant counter port is enabled by defining FP_NORM_PERF_EN.
module fp_norm_arbiter
  import fp_norm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [FP_W-1:0]         out_data,
  output logic [ID_W-1:0]         out_id,
  input  logic                    out_ready
`ifdef FP_NORM_PERF_EN
  ,
  output logic [15:0]             grant_cnt
`endif
);

  logic [ID_W-1:0]      ptr;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int unsigned          pick;
  int unsigned          sel;
  logic                 slot_free;
  logic                 xfer;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W-1:0]      next_ptr;
  logic [FP_W-1:0]      sel_word;
  logic [FP_W-1:0]      norm_word;
  logic [4:0]           norm_shift;

  assign slot_free = ~out_valid | out_ready;

  // Rotate valids so the pointer sits at bit 0, take the lowest set bit,
  // then add the pointer back modulo NUM_REQ.
  always_comb begin
    dbl   = {req_valid, req_valid};
    rot   = NUM_REQ'(dbl >> ptr);
    found = 1'b0;
    pick  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pick  = k;
      end
    end
    sel = 32'(ptr) + pick;
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    gnt_id   = ID_W'(sel);
    next_ptr = (sel + 1 >= NUM_REQ) ? '0 : ID_W'(sel + 1);
    xfer     = found & slot_free & ~rst;
  end

  always_comb begin
    req_ready = '0;
    sel_word  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == i) begin
        req_ready[i] = xfer;
        sel_word     = req_data[FP_W*i +: FP_W];
      end
    end
  end

  fp_norm_core u_core (
    .din   (sel_word),
    .dout  (norm_word),
    .shift (norm_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        assert (norm_shift <= 5'd23);
        out_valid <= 1'b1;
        out_data  <= norm_word;
        out_id    <= gnt_id;
        ptr       <= next_ptr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FP_NORM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                              grant_cnt <= '0;
    else if (xfer && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Scoreboard bench for fp_norm_arbiter: reference model predicts grants and normalized results.
module tb_fp_norm_arbiter;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [1:0]    out_id;
  logic          out_ready;
`ifdef FP_NORM_PERF_EN
  logic [15:0]   grant_cnt;
`endif

  fp_norm_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
`ifdef FP_NORM_PERF_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [33:0] sb[$];

  // Model state: output register, pointer, counter
  logic        m_ov;
  logic [31:0] m_data;
  int unsigned m_id;
  int unsigned m_ptr;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] norm_ref(input logic [31:0] w);
    int unsigned e, f, p, sh;
    logic s;
    s = w[31];
    e = 32'(w[30:23]);
    f = 32'(w[22:0]);
    if (f == 0) return w;
    p = 22;
    while (((f >> p) & 1) == 0) p--;
    sh = 23 - p;
    f  = (f << sh) & 32'h007F_FFFF;
    if (e <= sh) return {s, 31'b0};
    return {s, 8'(e - sh), 23'(f)};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[22:0]  = '0;
      1: w[30:23] = 8'($urandom_range(0, 24));
      default: ;
    endcase
    return w;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*32-1:0] dat, input logic o);
    logic [N-1:0] exp_rdy;
    logic         sf, found;
    int unsigned  g;
    logic [31:0]  w;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_data = dat; out_ready = o;
    @(negedge clk);
    sf = !m_ov || o;
    found = 1'b0;
    g = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && v[(m_ptr + k) % N]) begin
        found = 1'b1;
        g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (found && sf && !r) ? N'(1) << g : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data_reg", out_data, m_data);
    chk("out_id_reg", 32'(out_id), m_id);
`ifdef FP_NORM_PERF_EN
    chk("grant_cnt", 32'(grant_cnt), m_cnt);
`endif
    if (r) begin
      m_ov = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
      sb.delete();
    end else if (found && sf) begin
      w = norm_ref(dat[32*g +: 32]);
      sb.push_back({2'(g), w});
      m_ov = 1'b1; m_data = w; m_id = g;
      m_ptr = (g + 1) % N;
      if (m_cnt != 32'hFFFF) m_cnt++;
    end else if (o) begin
      m_ov = 1'b0;
    end
  endtask

  // Monitor: every accepted output must match the oldest predicted result
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL sb_empty: got unexpected output %h id %0d", out_data, out_id);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e[31:0]);
          chk("sb_id", 32'(out_id), 32'(e[33:32]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N*32-1:0] d;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    m_ov = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = 0;

    chk("ref_shift", norm_ref(32'h4100_1000), 32'h3B80_0000);
    chk("ref_uflow", norm_ref(32'h8180_0001), 32'h8000_0000);
    chk("ref_fzero", norm_ref(32'h4080_0000), 32'h4080_0000);

    step(1'b0, '0, '0, 1'b1);
    d = '0; d[31:0] = 32'h4080_0000;
    step(1'b0, 4'b0001, d, 1'b1);
    d = '0; d[63:32] = 32'h4100_1000;
    step(1'b0, 4'b0010, d, 1'b1);
    d = '0; d[95:64] = 32'h8180_0001;
    step(1'b0, 4'b0100, d, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // Round-robin from a fresh pointer
    step(1'b1, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < N; c++) d[32*c +: 32] = rnd_word();
      step(1'b0, 4'b1111, d, 1'b1);
    end

    // Backpressure then release
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, d, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, d, 1'b1);

    // Reset while holding a result
    step(1'b0, 4'b1111, d, 1'b0);
    step(1'b1, 4'b1111, d, 1'b0);
    step(1'b0, '0, d, 1'b0);
    step(1'b0, 4'b1111, d, 1'b1);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) d[32*c +: 32] = rnd_word();
      step(1'b0, N'($urandom), d, ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
